// File: rtl/perm_nibble_streamer.sv
// perm_nibble_streamer: ping-pong buffered word-to-nibble streamer that drives the upstream permutation select.
// Define PERM_CHECK_EN to flag accepted words that are not a permutation of lane values (sticky perm_err).
module perm_nibble_streamer #(
  parameter int NLANE = 16,
  parameter int LW    = 4,
  parameter int NPERM = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [NLANE*LW-1:0]       in_data,
  output logic [$clog2(NPERM)-1:0]  perm_sel,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [LW-1:0]             out_data,
  output logic [$clog2(NLANE)-1:0]  out_idx,
  output logic                      out_last,
  output logic [15:0]               seq_count,
  output logic                      perm_err
);
  localparam int IW = $clog2(NLANE);
  localparam int PW = $clog2(NPERM);
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;
  state_t               state_q, state_d;
  logic [NLANE*LW-1:0]  buf_q [2];
  logic                 wr_q, rd_q;
  logic [IW-1:0]        lane_q, lane_d;
  logic [PW-1:0]        psel_q;
  logic [15:0]          seq_q;
  logic                 acc, fire, pop;
  assign in_ready  = state_q != FULL;
  assign out_valid = state_q != EMPTY;
  assign acc       = in_valid && in_ready;
  assign fire      = out_valid && out_ready;
  assign pop       = fire && lane_q == IW'(NLANE - 1);
  assign out_data  = buf_q[rd_q][lane_q*LW +: LW];
  assign out_idx   = lane_q;
  assign out_last  = out_valid && lane_q == IW'(NLANE - 1);
  assign perm_sel  = psel_q;
  assign seq_count = seq_q;
  // occupancy only moves when exactly one of accept / final-lane pop happens
  assign state_d = (acc && !pop) ? (state_q == EMPTY ? ONE : FULL) :
                   (pop && !acc) ? (state_q == FULL ? ONE : EMPTY) : state_q;
  assign lane_d  = fire ? lane_q + 1'b1 : lane_q;
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= EMPTY;
      buf_q[0] <= '0;
      buf_q[1] <= '0;
      wr_q     <= 1'b0;
      rd_q     <= 1'b0;
      lane_q   <= '0;
      psel_q   <= '0;
      seq_q    <= '0;
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      if (acc) begin
        buf_q[wr_q] <= in_data;
        wr_q        <= ~wr_q;
        psel_q      <= psel_q + 1'b1;
      end
      if (pop) begin
        rd_q  <= ~rd_q;
        seq_q <= seq_q + 16'd1;
      end
    end
  end
`ifdef PERM_CHECK_EN
  logic             err_q;
  logic [NLANE-1:0] seen;
  if (LW == IW) begin : g_chk
    always_comb begin
      seen = '0;
      for (int i = 0; i < NLANE; i++) seen[in_data[i*LW +: LW]] = 1'b1;
    end
  end else begin : g_nochk
    assign seen = '1;
  end
  always_ff @(posedge clk) begin
    if (!rst) err_q <= 1'b0;
    else if (acc && !(&seen)) err_q <= 1'b1;
  end
  assign perm_err = err_q;
`else
  assign perm_err = 1'b0;
`endif
endmodule

// File: tb/tb_perm_nibble_streamer.sv
// tb_perm_nibble_streamer: scenario tasks plus a queue-based scoreboard for perm_nibble_streamer.
module tb_perm_nibble_streamer;
`ifdef PERM_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif
  logic        clk = 1'b0, rst = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic [63:0] in_data = '0;
  logic        in_ready, out_valid, out_last, perm_err;
  logic [2:0]  perm_sel;
  logic [3:0]  out_data, out_idx;
  logic [15:0] seq_count;
  int          n_vec = 0, n_bad = 0;

  always #5 clk = ~clk;

  perm_nibble_streamer dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .perm_sel(perm_sel), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_idx(out_idx), .out_last(out_last), .seq_count(seq_count), .perm_err(perm_err)
  );

  function automatic bit is_perm(input logic [63:0] w);
    bit [15:0] s = '0;
    for (int i = 0; i < 16; i++) s[w[i*4 +: 4]] = 1'b1;
    return &s;
  endfunction

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // scoreboard: words in flight as a queue, current lane as an integer
  logic [63:0] mq[$];
  logic [63:0] mw;
  int          ml = 0;
  logic [2:0]  mp = '0;
  logic [15:0] ms = '0;
  logic        me = 1'b0;
  bit          m_acc, m_pop;

  always @(negedge clk) begin
    if (!rst) begin
      mq.delete();
      ml = 0; mp = '0; ms = '0; me = 1'b0;
    end else begin
      n_vec += 5;
      if (in_ready !== (mq.size() != 2)) begin n_bad++; $display("FAIL mon_in_ready got %b exp %b", in_ready, mq.size() != 2); end
      if (out_valid !== (mq.size() != 0)) begin n_bad++; $display("FAIL mon_out_valid got %b exp %b", out_valid, mq.size() != 0); end
      if (perm_sel !== mp) begin n_bad++; $display("FAIL mon_perm_sel got %0d exp %0d", perm_sel, mp); end
      if (seq_count !== ms) begin n_bad++; $display("FAIL mon_seq_count got %0d exp %0d", seq_count, ms); end
      if (perm_err !== me) begin n_bad++; $display("FAIL mon_perm_err got %b exp %b", perm_err, me); end
      if (mq.size() > 0) begin
        mw = mq[0];
        n_vec += 3;
        if (out_data !== mw[ml*4 +: 4]) begin n_bad++; $display("FAIL mon_out_data got %h exp %h lane %0d", out_data, mw[ml*4 +: 4], ml); end
        if (out_idx !== 4'(ml)) begin n_bad++; $display("FAIL mon_out_idx got %0d exp %0d", out_idx, ml); end
        if (out_last !== (ml == 15)) begin n_bad++; $display("FAIL mon_out_last got %b exp %b", out_last, ml == 15); end
      end
      m_acc = in_valid && mq.size() < 2;
      m_pop = mq.size() > 0 && out_ready;
      if (m_pop) begin
        if (ml == 15) begin
          void'(mq.pop_front());
          ml = 0;
          ms++;
        end else ml++;
      end
      if (m_acc) begin
        mq.push_back(in_data);
        mp++;
        if (CHK && !is_perm(in_data)) me = 1'b1;
      end
    end
  end

  task automatic test_reset();
    rst = 1'b0;
    cyc(); cyc();
    rst = 1'b1;
    n_vec++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || perm_sel !== 3'd0 || seq_count !== 16'd0 ||
        perm_err !== 1'b0 || out_data !== 4'd0 || out_idx !== 4'd0 || out_last !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_values got rdy=%b vld=%b sel=%0d seq=%0d err=%b data=%h idx=%0d last=%b exp 1 0 0 0 0 0 0 0",
               in_ready, out_valid, perm_sel, seq_count, perm_err, out_data, out_idx, out_last);
    end
  endtask

  task automatic test_single();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 64'hFEDCBA9876543210;
    cyc();
    in_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      n_vec++;
      if (out_valid !== 1'b1 || out_data !== 4'(i) || out_idx !== 4'(i) || out_last !== (i == 15)) begin
        n_bad++;
        $display("FAIL single_lane%0d got vld=%b data=%h idx=%0d last=%b exp 1 %h %0d %b",
                 i, out_valid, out_data, out_idx, out_last, 4'(i), i, i == 15);
      end
      cyc();
    end
    n_vec++;
    if (seq_count !== 16'd1 || perm_sel !== 3'd1 || out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL single_after got seq=%0d sel=%0d vld=%b exp 1 1 0", seq_count, perm_sel, out_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] w [3];
    int k = 0, run = 0, ir0 = 0, first_last = -1, acc_c = -1;
    bit acc, ended = 1'b0;
    for (int i = 0; i < 3; i++) w[i] = rnd64();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = w[0];
    for (int c = 0; c < 80; c++) begin
      acc = in_valid && in_ready;
      if (out_valid && !ended) run++;
      else if (!out_valid && run > 0) ended = 1'b1;
      if (k == 2 && in_valid && !in_ready) ir0++;
      if (k == 2 && acc) acc_c = c;
      if (out_valid && out_last && first_last < 0) first_last = c;
      cyc();
      if (acc) begin
        k++;
        in_valid = k < 3;
        in_data  = k < 3 ? w[k] : 64'd0;
      end
    end
    in_valid = 1'b0;
    n_vec += 3;
    if (run !== 48) begin n_bad++; $display("FAIL b2b_valid_run got %0d exp 48", run); end
    if (ir0 !== 15) begin n_bad++; $display("FAIL b2b_ready_low_cycles got %0d exp 15", ir0); end
    if (first_last < 0 || acc_c !== first_last + 1) begin
      n_bad++;
      $display("FAIL b2b_third_accept got cycle %0d exp %0d", acc_c, first_last + 1);
    end
  endtask

  task automatic test_stall();
    logic [63:0] w = rnd64();
    logic [3:0]  d;
    int n = 0;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = w;
    cyc();
    in_valid = 1'b0;
    while (!(out_valid && out_idx == 4'd7) && n < 40) begin cyc(); n++; end
    n_vec++;
    if (n >= 40) begin n_bad++; $display("FAIL stall_reach_idx7 got timeout exp idx 7"); end
    out_ready = 1'b0;
    d = out_data;
    n_vec++;
    if (d !== w[31:28]) begin n_bad++; $display("FAIL stall_lane7_data got %h exp %h", d, w[31:28]); end
    for (int i = 0; i < 5; i++) begin
      cyc();
      n_vec++;
      if (out_valid !== 1'b1 || out_idx !== 4'd7 || out_data !== d) begin
        n_bad++;
        $display("FAIL stall_hold%0d got vld=%b idx=%0d data=%h exp 1 7 %h", i, out_valid, out_idx, out_data, d);
      end
    end
    out_ready = 1'b1;
    for (int i = 7; i < 16; i++) begin
      n_vec++;
      if (out_valid !== 1'b1 || out_idx !== 4'(i) || out_data !== w[i*4 +: 4]) begin
        n_bad++;
        $display("FAIL stall_resume%0d got vld=%b idx=%0d data=%h exp 1 %0d %h", i, out_valid, out_idx, out_data, i, w[i*4 +: 4]);
      end
      cyc();
    end
    n_vec++;
    if (out_valid !== 1'b0) begin n_bad++; $display("FAIL stall_drained got vld=%b exp 0", out_valid); end
  endtask

  task automatic test_seq9_reset();
    int n;
    rst = 1'b0;
    cyc(); cyc();
    rst = 1'b1;
    out_ready = 1'b1;
    for (int j = 0; j < 9; j++) begin
      in_valid = 1'b1;
      in_data  = rnd64();
      n = 0;
      while (!in_ready && n < 40) begin cyc(); n++; end
      n_vec++;
      if (!in_ready || perm_sel !== 3'(j % 8)) begin
        n_bad++;
        $display("FAIL seq9_sel_word%0d got rdy=%b sel=%0d exp 1 %0d", j, in_ready, perm_sel, j % 8);
      end
      cyc();
    end
    in_valid = 1'b0;
    n = 0;
    while (out_valid && n < 400) begin cyc(); n++; end
    n_vec++;
    if (out_valid !== 1'b0 || perm_sel !== 3'd1 || seq_count !== 16'd9) begin
      n_bad++;
      $display("FAIL seq9_end got vld=%b sel=%0d seq=%0d exp 0 1 9", out_valid, perm_sel, seq_count);
    end
    in_valid = 1'b1;
    in_data  = rnd64();
    cyc();
    in_valid = 1'b0;
    n = 0;
    while (!(out_valid && out_idx == 4'd4) && n < 40) begin cyc(); n++; end
    n_vec++;
    if (n >= 40) begin n_bad++; $display("FAIL seq9_reach_idx4 got timeout exp idx 4"); end
    rst = 1'b0;
    cyc();
    n_vec++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || perm_sel !== 3'd0 || seq_count !== 16'd0 ||
        perm_err !== 1'b0 || out_data !== 4'd0 || out_idx !== 4'd0 || out_last !== 1'b0) begin
      n_bad++;
      $display("FAIL midstream_reset got rdy=%b vld=%b sel=%0d seq=%0d err=%b data=%h idx=%0d last=%b exp 1 0 0 0 0 0 0 0",
               in_ready, out_valid, perm_sel, seq_count, perm_err, out_data, out_idx, out_last);
    end
    cyc();
    rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      n_vec++;
      if (out_valid !== 1'b0) begin n_bad++; $display("FAIL partial_word_emitted cycle %0d got vld=%b exp 0", i, out_valid); end
      cyc();
    end
  endtask

  task automatic test_perm_check();
    int emitted = 0;
    out_ready = 1'b1;
    n_vec++;
    if (perm_err !== 1'b0) begin n_bad++; $display("FAIL perm_err_before got %b exp 0", perm_err); end
    in_valid = 1'b1;
    in_data  = 64'h0;
    cyc();
    in_data = 64'hFEDCBA9876543210;
    n_vec++;
    if (perm_err !== CHK) begin n_bad++; $display("FAIL perm_err_after_accept got %b exp %b", perm_err, CHK); end
    if (out_valid && out_ready) emitted++;
    cyc();
    in_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      n_vec++;
      if (perm_err !== CHK) begin n_bad++; $display("FAIL perm_err_sticky cycle %0d got %b exp %b", i, perm_err, CHK); end
      if (out_valid && out_ready) emitted++;
      cyc();
    end
    n_vec++;
    if (emitted !== 32) begin n_bad++; $display("FAIL perm_words_streamed got %0d exp 32", emitted); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_seq9_reset();
    test_perm_check();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
